// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: event codes shared by the button debounce and event arbiter blocks
package btn_evt_pkg;
    typedef logic [1:0] btn_evt_t;
    localparam btn_evt_t EVT_NONE    = 2'd0;
    localparam btn_evt_t EVT_PRESS   = 2'd1;
    localparam btn_evt_t EVT_RELEASE = 2'd2;
    localparam btn_evt_t EVT_LONG    = 2'd3;
endpackage

// File: rtl/btn_debounce_core.sv
// btn_debounce_core: synchroniser, tick-sampled debouncer and optional long-press timer for one button
//   clk      system clock
//   rst      asynchronous active-low reset
//   btn      raw asynchronous button level, 1 = pressed
//   tick     sample strobe from the shared prescaler
//   level    debounced level
//   post     one-cycle strobe, asserted in the cycle whose clock edge updates level/long timer
//   post_evt event code carried by post
//   BTN_LONG_PRESS_EN builds the long-press timer
module btn_debounce_core
    import btn_evt_pkg::*;
#(
    parameter int STABLE_CNT = 8,
    parameter int LONG_CNT   = 500
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     btn,
    input  logic     tick,
    output logic     level,
    output logic     post,
    output btn_evt_t post_evt
);
    logic [1:0] r_sync;
    logic [7:0] r_cnt;
    logic       r_level;
    logic       w_diff;
    logic       w_flip;
    logic       w_long;

    assign w_diff = tick && (r_sync[1] != r_level);
    assign w_flip = w_diff && (r_cnt == 8'(STABLE_CNT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn};
            if (tick) r_cnt <= (w_diff && !w_flip) ? r_cnt + 8'd1 : 8'd0;
            if (w_flip) r_level <= !r_level;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CNT + 1);
    logic [LW-1:0] r_long;

    // a level flip in the same tick wins over the long-press event
    assign w_long = tick && r_level && !w_flip && (r_long == LW'(LONG_CNT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_long <= '0;
        else if (w_flip) r_long <= '0;
        else if (tick && r_level && (r_long != LW'(LONG_CNT))) r_long <= r_long + LW'(1);
    end
`else
    // LONG_CNT has no effect without the long-press timer
    assign w_long = 1'b0 && (LONG_CNT != 0);
`endif

    assign level    = r_level;
    assign post     = w_flip || w_long;
    assign post_evt = w_flip ? (r_level ? EVT_RELEASE : EVT_PRESS) : (w_long ? EVT_LONG : EVT_NONE);
endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounces N_BTN buttons and serialises their events onto one valid/ready port
//   clk       system clock
//   rst       asynchronous active-low reset
//   btn       raw button levels, 1 = pressed
//   level     debounced levels
//   evt_valid event presented
//   evt_ready consumer accepts the event
//   evt_id    source button index
//   evt_type  1 PRESS, 2 RELEASE, 3 LONG
//   overrun   sticky: a pending event was overwritten
//   BTN_LONG_PRESS_EN enables LONG events
module btn_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter  int N_BTN      = 4,
    parameter  int TICK_DIV   = 1000,
    parameter  int STABLE_CNT = 8,
    parameter  int LONG_CNT   = 500,
    localparam int IDW        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDW-1:0]   evt_id,
    output btn_evt_t         evt_type,
    output logic             overrun
);
    localparam int DW = $clog2(TICK_DIV);

    logic [DW-1:0]  r_div;
    logic           w_tick;
    logic [N_BTN-1:0] w_post;
    btn_evt_t       w_post_evt [N_BTN];
    btn_evt_t       r_slot [N_BTN];
    logic [IDW-1:0] r_last;
    logic           r_valid;
    logic [IDW-1:0] r_id;
    btn_evt_t       r_type;
    logic           r_overrun;
    logic [IDW-1:0] w_cand;
    logic [IDW-1:0] w_gidx;
    logic           w_found;
    logic           w_free;
    logic           w_grant;

    assign w_tick = (r_div == DW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_div <= '0;
        else r_div <= w_tick ? '0 : r_div + DW'(1);
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce_core #(
            .STABLE_CNT(STABLE_CNT),
            .LONG_CNT  (LONG_CNT)
        ) u_core (
            .clk     (clk),
            .rst     (rst),
            .btn     (btn[i]),
            .tick    (w_tick),
            .level   (level[i]),
            .post    (w_post[i]),
            .post_evt(w_post_evt[i])
        );
    end

    // round-robin: first non-empty slot after the last grant, wrapping
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            w_cand = IDW'((int'(r_last) + k) % N_BTN);
            if (!w_found && (r_slot[w_cand] != EVT_NONE)) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    assign w_free  = !r_valid || evt_ready;
    assign w_grant = w_free && w_found;

    // a post to the slot being granted replaces the granted value without overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_BTN; k++) r_slot[k] <= EVT_NONE;
            r_overrun <= 1'b0;
        end else begin
            for (int k = 0; k < N_BTN; k++) begin
                if (w_post[k]) begin
                    r_slot[k] <= w_post_evt[k];
                    if ((r_slot[k] != EVT_NONE) && !(w_grant && (w_gidx == IDW'(k)))) r_overrun <= 1'b1;
                end else if (w_grant && (w_gidx == IDW'(k))) begin
                    r_slot[k] <= EVT_NONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_type  <= EVT_NONE;
            r_last  <= IDW'(N_BTN - 1);
        end else if (w_grant) begin
            r_valid <= 1'b1;
            r_id    <= w_gidx;
            r_type  <= r_slot[w_gidx];
            r_last  <= w_gidx;
        end else if (w_free) begin
            r_valid <= 1'b0;
        end
    end

    assign evt_valid = r_valid;
    assign evt_id    = r_id;
    assign evt_type  = r_type;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed and random stimulus against an event-level reference model
module tb_btn_event_arbiter;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int LC = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] level;
    logic         evt_valid;
    logic         evt_ready = 1'b0;
    logic [1:0]   evt_id;
    logic [1:0]   evt_type;
    logic         overrun;

    btn_event_arbiter #(
        .N_BTN(N), .TICK_DIV(TD), .STABLE_CNT(SC), .LONG_CNT(LC)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .level(level),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_type(evt_type), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model: per button the last two raw samples, accepted level, count of
    // consecutive disagreeing ticks, ticks held; pending slot per button
    bit m_sh0 [N];
    bit m_sh1 [N];
    bit m_lvl [N];
    int m_dc [N];
    int m_held [N];
    int m_slot [N];
    int m_lastg, m_phase, m_id, m_ty;
    bit m_v, m_ov;

    typedef struct {int id; int ty; int cyc;} ev_t;
    ev_t log_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_sh0[i] = 0; m_sh1[i] = 0; m_lvl[i] = 0;
            m_dc[i] = 0; m_held[i] = 0; m_slot[i] = 0;
        end
        m_lastg = N - 1; m_phase = 0; m_id = 0; m_ty = 0; m_v = 0; m_ov = 0;
    endtask

    // state after the coming clock edge, given the inputs held now
    task automatic m_step();
        bit tck;
        bit free;
        int g;
        int post [N];
        tck  = (m_phase == TD - 1);
        free = !m_v || evt_ready;
        g = -1;
        for (int k = 1; k <= N; k++)
            if (g < 0 && m_slot[(m_lastg + k) % N] != 0) g = (m_lastg + k) % N;
        for (int i = 0; i < N; i++) begin
            post[i] = 0;
            if (tck) begin
                if (m_sh1[i] == m_lvl[i]) m_dc[i] = 0;
                else begin
                    m_dc[i]++;
                    if (m_dc[i] == SC) begin
                        m_dc[i] = 0;
                        post[i] = m_lvl[i] ? 2 : 1;
                        m_lvl[i] = !m_lvl[i];
                        m_held[i] = 0;
                    end
                end
`ifdef BTN_LONG_PRESS_EN
                if (post[i] == 0 && m_lvl[i] && m_held[i] < LC) begin
                    m_held[i]++;
                    if (m_held[i] == LC) post[i] = 3;
                end
`endif
            end
        end
        for (int i = 0; i < N; i++)
            if (post[i] != 0 && m_slot[i] != 0 && !(free && g == i)) m_ov = 1;
        if (free && g >= 0) begin
            m_v = 1; m_id = g; m_ty = m_slot[g]; m_lastg = g;
        end else if (free) m_v = 0;
        for (int i = 0; i < N; i++) begin
            if (post[i] != 0) m_slot[i] = post[i];
            else if (free && g == i) m_slot[i] = 0;
            m_sh1[i] = m_sh0[i];
            m_sh0[i] = btn[i];
        end
        m_phase = (m_phase + 1) % TD;
    endtask

    always @(negedge clk) begin
        logic [N-1:0] mvec;
        cyc++;
        if (!rst) m_reset();
        for (int i = 0; i < N; i++) mvec[i] = m_lvl[i];
        chk("level", int'(level), int'(mvec));
        chk("evt_valid", int'(evt_valid), int'(m_v));
        chk("overrun", int'(overrun), int'(m_ov));
        if (m_v) begin
            chk("evt_id", int'(evt_id), m_id);
            chk("evt_type", int'(evt_type), m_ty);
        end
        if (rst && evt_valid && evt_ready) log_q.push_back('{int'(evt_id), int'(evt_type), cyc});
        if (rst) m_step();
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick_n(2);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        int bad;
        tick_n(3);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_id", int'(evt_id), 0);
        chk("rst_type", int'(evt_type), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b1;

        // bounce: alternate every cycle, phased so every tick samples 0
        evt_ready = 1'b1;
        tick_n(4);
        log_q.delete();
        for (int c = 0; c < 20; c++) begin
            btn[0] = (m_phase % 2 == 0);
            tick_n(1);
        end
        chk("bounce_no_events", log_q.size(), 0);
        chk("bounce_level", int'(level[0]), 0);
        btn[0] = 1'b1;
        n = 0;
        while (n < 40 && !level[0]) begin
            tick_n(1);
            n++;
        end
        chk("press_latency_11_to_14", int'(n >= 11 && n <= 14), 1);
        tick_n(5);
        chk("bounce_event_count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("bounce_id", log_q[0].id, 0);
            chk("bounce_type", log_q[0].ty, 1);
        end
        btn[0] = 1'b0;
        tick_n(25);
        chk("release_count", log_q.size(), 2);

        // round-robin after fresh reset
        do_reset();
        log_q.delete();
        evt_ready = 1'b0;
        btn = '1;
        tick_n(25);
        chk("rr_held_valid", int'(evt_valid), 1);
        chk("rr_held_id", int'(evt_id), 0);
        evt_ready = 1'b1;
        tick_n(6);
        chk("rr_press_count", log_q.size(), 4);
        for (int k = 0; k < 4 && k < log_q.size(); k++) begin
            chk("rr_press_id", log_q[k].id, k);
            chk("rr_press_type", log_q[k].ty, 1);
            if (k > 0) chk("rr_press_spacing", log_q[k].cyc - log_q[k-1].cyc, 1);
        end
        log_q.delete();
        evt_ready = 1'b0;
        btn = '0;
        tick_n(25);
        evt_ready = 1'b1;
        tick_n(6);
        chk("rr_rel_count", log_q.size(), 4);
        for (int k = 0; k < 4 && k < log_q.size(); k++) begin
            chk("rr_rel_id", log_q[k].id, k);
            chk("rr_rel_type", log_q[k].ty, 2);
        end

        // backpressure
        log_q.delete();
        evt_ready = 1'b0;
        btn[2] = 1'b1;
        tick_n(20);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_type !== 2'd1) bad++;
            tick_n(1);
        end
        chk("bp_unstable_cycles", bad, 0);
        evt_ready = 1'b1;
        tick_n(1);
        chk("bp_accept_first_cycle", log_q.size(), 1);
        if (log_q.size() > 0) chk("bp_accepted_id", log_q[0].id, 2);
        btn[2] = 1'b0;
        tick_n(30);

        // overrun on slot 1 while the register holds button 3
        do_reset();
        log_q.delete();
        evt_ready = 1'b0;
        btn[3] = 1'b1;
        tick_n(20);
        btn[1] = 1'b1;
        tick_n(20);
        btn[1] = 1'b0;
        tick_n(20);
        btn[1] = 1'b1;
        tick_n(20);
        chk("ovr_flag", int'(overrun), 1);
        evt_ready = 1'b1;
        tick_n(5);
        chk("ovr_enough_events", int'(log_q.size() >= 2), 1);
        if (log_q.size() >= 2) begin
            chk("ovr_first_id", log_q[0].id, 3);
            chk("ovr_first_type", log_q[0].ty, 1);
            chk("ovr_second_id", log_q[1].id, 1);
            chk("ovr_second_type", log_q[1].ty, 1);
        end
        btn = '0;
        tick_n(30);

        // long press on button 2
        do_reset();
        log_q.delete();
        evt_ready = 1'b1;
        btn[2] = 1'b1;
        tick_n(45);
        btn[2] = 1'b0;
        tick_n(25);
`ifdef BTN_LONG_PRESS_EN
        chk("long_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("long_t0", log_q[0].ty, 1);
            chk("long_t1", log_q[1].ty, 3);
            chk("long_t2", log_q[2].ty, 2);
            chk("long_ticks", log_q[1].cyc - log_q[0].cyc, LC * TD);
        end
`else
        chk("long_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("long_t0", log_q[0].ty, 1);
            chk("long_t1", log_q[1].ty, 2);
        end
`endif

        // random traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) btn[i] = !btn[i];
            evt_ready = ($urandom_range(0, 3) != 0);
            tick_n(1);
        end
        btn = '0;
        evt_ready = 1'b1;
        tick_n(40);

        // reset mid-handshake with pending slots
        evt_ready = 1'b0;
        btn = '1;
        tick_n(25);
        chk("mid_valid_before", int'(evt_valid), 1);
        rst = 1'b0;
        btn = '0;
        #1;
        chk("mid_valid", int'(evt_valid), 0);
        chk("mid_id", int'(evt_id), 0);
        chk("mid_type", int'(evt_type), 0);
        chk("mid_level", int'(level), 0);
        chk("mid_overrun", int'(overrun), 0);
        tick_n(2);
        rst = 1'b1;
        log_q.delete();
        evt_ready = 1'b1;
        tick_n(40);
        chk("mid_no_stale", log_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Multi-button front end that debounces `N_BTN` raw button inputs and turns their state changes into a single stream of press, release and long-press events. Sample timing comes from one shared prescaler. A round-robin arbiter serialises the per-button events onto one valid/ready output port. The block sits between the board's button pins and the control logic that consumes user input.

## Interface
- `N_BTN`, 4: number of button inputs, 2..16.
- `TICK_DIV`, 1000: clk cycles per sample tick, ≥2.
- `STABLE_CNT`, 8: consecutive differing samples required to accept a new level, 2..255.
- `LONG_CNT`, 500: ticks held before a LONG event fires, ≥1.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btn`  in  N_BTN  raw, asynchronous button levels, 1 = pressed.
- `level`  out  N_BTN  debounced levels.
- `evt_valid`  out  1  an event is presented.
- `evt_ready`  in  1  the consumer accepts the event.
- `evt_id`  out  IDW = max(1,$clog2(N_BTN))  index of the source button.
- `evt_type`  out  2  event code: 1 PRESS, 2 RELEASE, 3 LONG.
- `overrun`  out  1  sticky flag: a pending event was overwritten.

## Operation
- **Synchroniser:** each `btn` bit passes through a 2-FF synchroniser.
- **Prescaler:** counts 0..TICK_DIV-1 and asserts `tick` for one cycle at the wrap.
- **Debounce, per button, on `tick` only:**
  - If the sample equals `level[i]`, the stability counter clears.
  - Otherwise the counter increments. On reaching STABLE_CNT, `level[i]` flips, the counter clears, and a PRESS (0→1) or RELEASE (1→0) event is posted.
- **Long press:** while `level[i]`=1, the long counter increments on each `tick`, saturating. When it reaches LONG_CNT, one LONG event is posted. The counter clears when `level[i]` flips.
- **Pending slot:** each button has a single 2-bit slot, 0 = empty.
  - Posting to an occupied slot that is not being granted in the same cycle overwrites it and sets `overrun`.
  - `overrun` clears only on reset.
- **Output register:** `evt_valid`, `evt_id`, `evt_type`.
  - The register is free when `evt_valid`=0, or when `evt_valid`&&`evt_ready` in this cycle.
  - When free and any slot is non-empty, the arbiter grants the first non-empty slot searching from `last_grant+1` with wrap-around. The register loads that slot, the slot clears, and `last_grant` updates.
  - A post and a grant to the same slot in the same cycle: the grant takes the old value and the slot takes the new one, with no overrun.
- **Handshake:** while `evt_valid`=1 && `evt_ready`=0, `evt_id` and `evt_type` hold stable.
- **Reset values:** `level`=0, `evt_valid`=0, `evt_id`=0, `evt_type`=0, `overrun`=0, all counters and slots 0, `last_grant`=N_BTN-1 so that button 0 has first priority.
  - Reset asserted mid-handshake drops the presented event.

## Timing
- Synchroniser latency: 2 cycles.
- Stable input to `level` flip: 2 + (STABLE_CNT-1)·TICK_DIV + 1..TICK_DIV cycles.
- `level` flips in the same cycle the event is posted.
- Post to `evt_valid`: 1 cycle if the output register is free and no other slot wins arbitration.
- Back-to-back events: one per cycle while `evt_ready`=1.
- Slot service worst case: N_BTN accepted events.

## Configuration
- `BTN_LONG_PRESS_EN`
  - Defined: long counters are built and LONG events are produced.
  - Undefined: long counters are removed, `evt_type` is never 3, and `LONG_CNT` is ignored.

## Structure
- Package `btn_evt_pkg`:
  - event-code localparams `EVT_NONE`/`EVT_PRESS`/`EVT_RELEASE`/`EVT_LONG`
  - a `btn_evt_t` 2-bit typedef
- Sub-module `btn_debounce_core`, one instance per button via generate. Inputs: `clk`, `rst`, raw `btn`, `tick`. Contents: synchroniser, stability counter, level, long counter. Outputs: `level` and a one-cycle `post` with its `btn_evt_t` code.
- The top level holds the prescaler, pending slots, arbiter and output register.

## Test plan
- **Bounce rejection:** TICK_DIV=4, STABLE_CNT=3; toggle `btn[0]` every 1 cycle for 20 cycles, then hold 1. Expect exactly one PRESS with id 0; `level[0]` rises 2 + 8 + (1..4) cycles after the hold starts; no events during the bounce.
- **Round-robin:** press btn 0..3 simultaneously with `evt_ready`=0, then raise `evt_ready`. Expect PRESS events in id order 0,1,2,3 on consecutive cycles. Repeat with release; after last_grant=3 the order is 0,1,2,3 again.
- **Backpressure:** hold `evt_ready`=0 for 50 cycles with an event presented. `evt_valid`, `evt_id` and `evt_type` stay constant; the event is accepted on the first `evt_ready`=1 cycle.
- **Overrun:** `evt_ready`=0; btn 1 presses, releases and presses again, all debounced. Result: slot holds PRESS, `overrun`=1, and a single PRESS is delivered.
- **Long press, `BTN_LONG_PRESS_EN` defined:** LONG_CNT=5; hold btn 2. Expect PRESS, then exactly one LONG 5 ticks after the level flip, then RELEASE on release. With the macro undefined, no LONG event appears.
- **Reset mid-operation:** assert `rst` low while `evt_valid`=1 and slots are pending. All outputs go to 0 immediately; after release, no stale events appear.
